chip_link_rx: RTL and testbench

- East/N/W/S chip-boundary receive stage of pcss_top.
- Accepts 16-bit flits from the external link over a 4-phase valid/ready handshake with even parity.
- Assembles four flits, MSB flit first, into one 64-bit packet (FW+CONNECT_WIDTH).
- Presents the packet to the on-chip mesh router through a valid/ready interface.

---
 rtl/chip_link_rx_if.sv | 26 ++
 rtl/chip_link_rx.sv | 173 +++++++++++++++++
 tb/tb_chip_link_rx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip_link_rx_if.sv
// Chip-boundary receive bundle: 4-phase flit link from the pins plus the
// valid/ready packet channel toward the mesh router.
interface chip_link_rx_if #(
    parameter int CHIPDATA_WIDTH = 16,
    parameter int PKT_W          = 64
);
    logic [CHIPDATA_WIDTH-1:0] recv_data_in;
    logic                      recv_data_valid;
    logic                      recv_data_par;
    logic                      recv_data_ready;
    logic                      recv_data_err;
    logic [PKT_W-1:0]          pkt_data;
    logic                      pkt_valid;
    logic                      pkt_ready;

    // master: external sender plus router; slave: the receive stage
    modport master (
        output recv_data_in, recv_data_valid, recv_data_par, pkt_ready,
        input  recv_data_ready, recv_data_err, pkt_data, pkt_valid
    );

    modport slave (
        input  recv_data_in, recv_data_valid, recv_data_par, pkt_ready,
        output recv_data_ready, recv_data_err, pkt_data, pkt_valid
    );
endinterface

// File: rtl/chip_link_rx.sv
// Chip-boundary receive stage: checks even parity on 4-phase flits, assembles
// FLITS flits MSB-first into one packet. Define CHIP_LINK_SYNC_EN to synchronize valid.
module chip_link_rx #(
    parameter int CHIPDATA_WIDTH = 16,
    parameter int FLITS          = 4,
    parameter int TIMEOUT_CYC    = 1024,
    parameter int ERRCNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    chip_link_rx_if.slave       lnk,
    output logic                drop_pulse,
    output logic [ERRCNT_W-1:0] err_cnt
);
    localparam int PKT_W = CHIPDATA_WIDTH * FLITS;
    localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    function automatic logic parity_ok(input logic [CHIPDATA_WIDTH-1:0] d, input logic p);
        return (^d) == p;
    endfunction

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PKT_W-1:0]    asm_q, asm_d;
    logic [PKT_W-1:0]    pkt_data_q, pkt_data_d;
    logic                pkt_valid_q, pkt_valid_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                drop_q, drop_d;
    logic                vld;
    logic                slot_free;
    logic                take;

`ifdef CHIP_LINK_SYNC_EN
    // Only valid is synchronized; data/parity are held stable by the 4-phase protocol.
    logic [1:0] vsync_q, vsync_d;
    assign vsync_d = {vsync_q[0], lnk.recv_data_valid};
    assign vld     = vsync_q[1];
`else
    assign vld = lnk.recv_data_valid;
`endif

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        err_cnt_d   = err_cnt_q;
        wd_d        = wd_q;
        drop_d      = 1'b0;
        take        = 1'b0;
        slot_free   = !pkt_valid_q || lnk.pkt_ready;

        if (pkt_valid_q && lnk.pkt_ready) begin
            pkt_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (vld) begin
                    // The final flit may only be taken when the output slot can accept the packet.
                    if (cnt_q != LAST_FLIT || slot_free) begin
                        take = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    take = 1'b1;
                end
            end
            ACK: begin
                if (!vld) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = ACK;
            ready_d = 1'b1;
            wd_d    = '0;
            if (parity_ok(lnk.recv_data_in, lnk.recv_data_par)) begin
                err_d = 1'b0;
                for (int f = 0; f < FLITS; f++) begin
                    if (cnt_q == CNT_W'(f)) begin
                        asm_d[PKT_W-1-CHIPDATA_WIDTH*f -: CHIPDATA_WIDTH] = lnk.recv_data_in;
                    end
                end
                if (cnt_q == LAST_FLIT) begin
                    pkt_data_d  = asm_d;
                    pkt_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                // Rejected flit: sender repeats it, so the slot index stays put.
                err_d     = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end else if (TIMEOUT_CYC > 0 && state_q == IDLE && cnt_q != '0 && !vld) begin
            if (wd_q == WD_LIMIT) begin
                wd_d   = '0;
                cnt_d  = '0;
                drop_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            err_cnt_q   <= '0;
            wd_q        <= '0;
            drop_q      <= 1'b0;
`ifdef CHIP_LINK_SYNC_EN
            vsync_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            err_cnt_q   <= err_cnt_d;
            wd_q        <= wd_d;
            drop_q      <= drop_d;
`ifdef CHIP_LINK_SYNC_EN
            vsync_q     <= vsync_d;
`endif
        end
    end

    // Assembly buffer needs no reset: every field is rewritten before a packet completes.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign lnk.recv_data_ready = ready_q;
    assign lnk.recv_data_err   = err_q;
    assign lnk.pkt_data        = pkt_data_q;
    assign lnk.pkt_valid       = pkt_valid_q;
    assign drop_pulse          = drop_q;
    assign err_cnt             = err_cnt_q;
endmodule

// File: tb/tb_chip_link_rx.sv
// Directed self-checking bench for chip_link_rx (watchdog shortened to 16 cycles).
module tb_chip_link_rx;
`ifdef CHIP_LINK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [63:0] PKT_REF = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] PKT_A   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PKT_B   = 64'hCAFE_BABE_0123_4567;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       drop_pulse;
    logic [7:0] err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    logic [63:0] xfer_data = '0;
    logic        ack_pv;
    logic [63:0] ack_pd;

    always #5 clk = ~clk;

    chip_link_rx_if #(.CHIPDATA_WIDTH(16), .PKT_W(64)) lnk ();

    chip_link_rx #(
        .CHIPDATA_WIDTH(16),
        .FLITS(4),
        .TIMEOUT_CYC(16),
        .ERRCNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lnk(lnk),
        .drop_pulse(drop_pulse),
        .err_cnt(err_cnt)
    );

    // Router-side observer: records every packet handed over.
    always @(negedge clk) begin
        if (rst_n && lnk.pkt_valid && lnk.pkt_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            xfer_data <= lnk.pkt_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [15:0] d, input logic p, input logic exp_err, input string tag);
        int n;
        lnk.recv_data_in    = d;
        lnk.recv_data_par   = p;
        lnk.recv_data_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!lnk.recv_data_ready && n < 200);
        ack_pv = lnk.pkt_valid;
        ack_pd = lnk.pkt_data;
        chk({tag, "_ack"}, 64'(lnk.recv_data_ready), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_err"}, 64'(lnk.recv_data_err), 64'(exp_err));
        lnk.recv_data_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (lnk.recv_data_ready && n < 200);
        chk({tag, "_rel"}, 64'(lnk.recv_data_ready), 64'd0);
        chk({tag, "_rel_err"}, 64'(lnk.recv_data_err), 64'd0);
    endtask

    task automatic send_good(input logic [15:0] d, input string tag);
        send_flit(d, ^d, 1'b0, tag);
    endtask

    task automatic send_pkt(input logic [63:0] p, input string tag);
        send_good(p[63:48], tag);
        send_good(p[47:32], tag);
        send_good(p[31:16], tag);
        send_good(p[15:0], tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(lnk.recv_data_ready), 64'd0);
        chk({tag, "_err"},   64'(lnk.recv_data_err), 64'd0);
        chk({tag, "_pv"},    64'(lnk.pkt_valid), 64'd0);
        chk({tag, "_pd"},    lnk.pkt_data, 64'd0);
        chk({tag, "_drop"},  64'(drop_pulse), 64'd0);
        chk({tag, "_ecnt"},  64'(err_cnt), 64'd0);
    endtask

    initial begin
        int x0;
        int n;
        int drop_cnt;
        int drop_at;

        rst_n               = 1'b0;
        lnk.recv_data_in    = '0;
        lnk.recv_data_par   = 1'b0;
        lnk.recv_data_valid = 1'b0;
        lnk.pkt_ready       = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Basic packet with the router always ready.
        lnk.pkt_ready = 1'b1;
        x0 = xfer_cnt;
        send_pkt(PKT_REF, "p1");
        chk("p1_pv_at_ack", 64'(ack_pv), 64'd1);
        chk("p1_pd_at_ack", ack_pd, PKT_REF);
        chk("p1_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));
        chk("p1_xfer_data", xfer_data, PKT_REF);
        chk("p1_pv_after", 64'(lnk.pkt_valid), 64'd0);
        chk("p1_ecnt", 64'(err_cnt), 64'd0);

        // Parity error on flit 2, then retransmission.
        x0 = xfer_cnt;
        send_good(16'h1234, "p2f1");
        send_flit(16'h5678, 1'b1, 1'b1, "p2bad");
        chk("p2_ecnt_bad", 64'(err_cnt), 64'd1);
        send_flit(16'h5678, 1'b0, 1'b0, "p2retx");
        send_good(16'h9ABC, "p2f3");
        send_good(16'hDEF0, "p2f4");
        chk("p2_pd_at_ack", ack_pd, PKT_REF);
        chk("p2_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));
        chk("p2_xfer_data", xfer_data, PKT_REF);
        chk("p2_ecnt", 64'(err_cnt), 64'd1);

        // Back-pressure: second packet's last flit must wait in HOLD.
        lnk.pkt_ready = 1'b0;
        x0 = xfer_cnt;
        send_pkt(PKT_A, "pa");
        chk("pa_pv", 64'(ack_pv), 64'd1);
        chk("pa_pd", ack_pd, PKT_A);
        send_good(PKT_B[63:48], "pb");
        send_good(PKT_B[47:32], "pb");
        send_good(PKT_B[31:16], "pb");
        chk("pa_held_pv", 64'(lnk.pkt_valid), 64'd1);
        chk("pa_held_pd", lnk.pkt_data, PKT_A);
        lnk.recv_data_in    = PKT_B[15:0];
        lnk.recv_data_par   = ^PKT_B[15:0];
        lnk.recv_data_valid = 1'b1;
        repeat (6) tick();
        chk("hold_ready", 64'(lnk.recv_data_ready), 64'd0);
        chk("hold_pd", lnk.pkt_data, PKT_A);
        chk("hold_no_xfer", 64'(xfer_cnt), 64'(x0));
        lnk.pkt_ready = 1'b1;
        tick();
        chk("release_ready", 64'(lnk.recv_data_ready), 64'd1);
        chk("release_err", 64'(lnk.recv_data_err), 64'd0);
        chk("release_pv", 64'(lnk.pkt_valid), 64'd1);
        chk("release_pd", lnk.pkt_data, PKT_B);
        chk("release_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));
        chk("release_xfer_data", xfer_data, PKT_A);
        lnk.pkt_ready       = 1'b0;
        lnk.recv_data_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (lnk.recv_data_ready && n < 200);
        chk("pb_rel", 64'(lnk.recv_data_ready), 64'd0);
        chk("pb_held_pd", lnk.pkt_data, PKT_B);
        lnk.pkt_ready = 1'b1;
        tick();
        chk("pb_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 2));
        chk("pb_xfer_data", xfer_data, PKT_B);
        chk("pb_pv_after", 64'(lnk.pkt_valid), 64'd0);

        // Watchdog: two flits then silence; partial packet dropped at idle cycle 16.
        send_good(16'h1357, "wd");
        send_good(16'h2468, "wd");
        drop_cnt = 0;
        drop_at  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (drop_pulse) begin
                drop_cnt++;
                drop_at = i;
            end
        end
        chk("wd_drop_count", 64'(drop_cnt), 64'd1);
        chk("wd_drop_cycle", 64'(drop_at), 64'd16);
        x0 = xfer_cnt;
        send_pkt(64'hAAAA_AAAA_AAAA_AAAA, "wdpkt");
        chk("wd_pd", ack_pd, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("wd_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));

        // Reset after three flits wipes the partial packet.
        send_good(16'hFFFF, "mr");
        send_good(16'hFFFF, "mr");
        send_good(16'hFFFF, "mr");
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("mrst");
        rst_n = 1'b1;
        tick();
        x0 = xfer_cnt;
        send_pkt(64'h0001_0002_0003_0004, "fresh");
        chk("fresh_pd", ack_pd, 64'h0001_0002_0003_0004);
        chk("fresh_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));
        chk("fresh_xfer_data", xfer_data, 64'h0001_0002_0003_0004);

        // Saturating error counter.
        for (int i = 1; i <= 300; i++) begin
            send_flit(16'h0000, 1'b1, 1'b1, "perr");
            if (i == 254) chk("ecnt_254", 64'(err_cnt), 64'hFE);
            if (i == 255) chk("ecnt_255", 64'(err_cnt), 64'hFF);
        end
        chk("ecnt_sat", 64'(err_cnt), 64'hFF);
        x0 = xfer_cnt;
        send_pkt(PKT_REF, "post");
        chk("post_pd", ack_pd, PKT_REF);
        chk("post_xfer_cnt", 64'(xfer_cnt), 64'(x0 + 1));
        chk("post_ecnt", 64'(err_cnt), 64'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
